ycr_burst_arb: RTL and testbench

- Round-robin arbiter with burst lock. Shares one downstream memory port (req/req_ack/resp) among TREQ requesters.
- Holds each grant from request acceptance until the last-data response (lack), so a burst is never split between masters.
- Includes a watchdog timeout that releases a grant when the target never signals lack.
- Sits between the per-core imem/dmem request sources and the shared core memory interface mux.

---
 rtl/ycr_burst_arb.sv | 123 ++++++++++++
 tb/tb_ycr_burst_arb.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/ycr_burst_arb.sv
// Round-robin arbiter with burst lock for a shared memory port.
// A grant is held from acceptance to last-data (or watchdog expiry), then re-arbitrated without a bubble.
module ycr_burst_arb #(
  parameter int TREQ   = 4,
  parameter int GW     = $clog2(TREQ),
  parameter int TOUT_W = 8,
  parameter int TOUT   = 200
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [TREQ-1:0] req,
  input  logic            req_ack,
  input  logic            lack,
  output logic [GW-1:0]   gnt,
  output logic            gnt_vld,
  output logic [TREQ-1:0] gnt_oh,
  output logic            busy,
  output logic            tout_err,
  output logic [GW-1:0]   tout_id
);

  if (TOUT < 0 || TOUT >= (1 << TOUT_W)) begin : g_tout_chk
    $error("ycr_burst_arb: TOUT does not fit in TOUT_W");
  end
  if (TREQ < 2 || TREQ > 8) begin : g_treq_chk
    $error("ycr_burst_arb: TREQ must be in 2..8");
  end

  typedef enum logic [1:0] {IDLE, GRANT, DATA} state_t;

  localparam logic [TOUT_W-1:0] TOUT_LAST = TOUT_W'((TOUT == 0) ? 0 : TOUT - 1);
  localparam logic [TOUT_W-1:0] CNT_MAX   = {TOUT_W{1'b1}};

  state_t            state, state_nxt;
  logic [GW-1:0]     rr_ptr, rr_ptr_nxt;
  logic [GW-1:0]     gnt_nxt, tout_id_nxt;
  logic [TREQ-1:0]   gnt_oh_nxt;
  logic              gnt_vld_nxt, busy_nxt, tout_err_nxt;
  logic [TOUT_W-1:0] cnt, cnt_nxt;
  logic [GW:0]       pick_idle, pick_done;
  logic              tout_fire, done;

  // Returns {found, index}; the search starts one past ptr, so ptr itself has lowest priority.
  function automatic logic [GW:0] arb(input logic [TREQ-1:0] r, input logic [GW-1:0] ptr);
    logic [GW:0] res;
    int          idx;
    res = '0;
    for (int i = TREQ; i >= 1; i--) begin
      idx = (int'(ptr) + i) % TREQ;
      if (r[idx]) res = {1'b1, GW'(idx)};
    end
    return res;
  endfunction

  assign pick_idle = arb(req, rr_ptr);
  assign pick_done = arb(req, gnt);
  assign tout_fire = (TOUT != 0) && (state == DATA) && !lack && (cnt == TOUT_LAST);
  assign done      = ((state == GRANT) && req_ack && lack) ||
                     ((state == DATA) && (lack || tout_fire));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      cnt      <= '0;
      gnt      <= '0;
      gnt_vld  <= 1'b0;
      gnt_oh   <= '0;
      busy     <= 1'b0;
      tout_err <= 1'b0;
      tout_id  <= '0;
    end else begin
      state    <= state_nxt;
      rr_ptr   <= rr_ptr_nxt;
      cnt      <= cnt_nxt;
      gnt      <= gnt_nxt;
      gnt_vld  <= gnt_vld_nxt;
      gnt_oh   <= gnt_oh_nxt;
      busy     <= busy_nxt;
      tout_err <= tout_err_nxt;
      tout_id  <= tout_id_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|req) state_nxt = GRANT;
      GRANT: begin
        if (req_ack && !lack)         state_nxt = DATA;
        else if (!req_ack && !req[gnt]) state_nxt = IDLE;
      end
      DATA:    state_nxt = DATA;
      default: state_nxt = IDLE;
    endcase
    // Completion overrides everything: hand over directly to the next winner if any.
    if (done) state_nxt = pick_done[GW] ? GRANT : IDLE;
  end

  always_comb begin
    gnt_nxt      = gnt;
    rr_ptr_nxt   = rr_ptr;
    tout_err_nxt = 1'b0;
    tout_id_nxt  = tout_id;
    cnt_nxt      = cnt;
    if (state == IDLE && pick_idle[GW]) gnt_nxt = pick_idle[GW-1:0];
    if (state == GRANT) cnt_nxt = '0;
    if (state == DATA)  cnt_nxt = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
    if (done) begin
      rr_ptr_nxt = gnt;
      if (pick_done[GW]) gnt_nxt = pick_done[GW-1:0];
    end
    if (tout_fire) begin
      tout_err_nxt = 1'b1;
      tout_id_nxt  = gnt;
    end
    gnt_vld_nxt = (state_nxt != IDLE);
    busy_nxt    = (state_nxt == DATA);
    gnt_oh_nxt  = '0;
    if (gnt_vld_nxt) gnt_oh_nxt[gnt_nxt] = 1'b1;
  end

endmodule

// File: tb/tb_ycr_burst_arb.sv
// Self-checking bench for ycr_burst_arb: directed scenarios plus random traffic against a behavioural model.
module tb_ycr_burst_arb;
  localparam int TREQ = 4;
  localparam int GW   = 2;
  localparam int TOUT = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [TREQ-1:0] req;
  logic            req_ack, lack;
  logic [GW-1:0]   gnt, tout_id;
  logic            gnt_vld, busy, tout_err;
  logic [TREQ-1:0] gnt_oh;

  int checks = 0;
  int errors = 0;

  // Behavioural model: current owner (-1 = none), whether its request was accepted, DATA age.
  int m_own, m_acc, m_age, m_ptr, m_gnt, m_terr, m_tid;

  ycr_burst_arb #(.TREQ(TREQ), .GW(GW), .TOUT_W(8), .TOUT(TOUT)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_ack(req_ack), .lack(lack),
    .gnt(gnt), .gnt_vld(gnt_vld), .gnt_oh(gnt_oh), .busy(busy),
    .tout_err(tout_err), .tout_id(tout_id)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL time_limit observed=running expected=finished");
    $fatal(1, "time limit");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [TREQ-1:0] r, input int from);
    for (int k = 1; k <= TREQ; k++)
      if (r[(from + k) % TREQ]) return (from + k) % TREQ;
    return -1;
  endfunction

  task automatic model_reset();
    m_own = -1; m_acc = 0; m_age = 0; m_ptr = 0; m_gnt = 0; m_terr = 0; m_tid = 0;
  endtask

  task automatic model_finish();
    int w;
    m_ptr = m_own;
    m_acc = 0;
    w = pick(req, m_ptr);
    m_own = w;
    if (w >= 0) m_gnt = w;
  endtask

  task automatic model_step();
    int w;
    m_terr = 0;
    if (m_own < 0) begin
      w = pick(req, m_ptr);
      if (w >= 0) begin m_own = w; m_gnt = w; end
    end else if (m_acc == 0) begin
      if (req_ack && lack)  model_finish();
      else if (req_ack)     begin m_acc = 1; m_age = 0; end
      else if (!req[m_own]) m_own = -1;
    end else begin
      if (lack) model_finish();
      else if (m_age == TOUT - 1) begin
        m_terr = 1; m_tid = m_own; model_finish();
      end else m_age = (m_age < 255) ? m_age + 1 : 255;
    end
  endtask

  task automatic cmp_model();
    chk("gnt",      32'(gnt),      32'(m_gnt));
    chk("gnt_vld",  32'(gnt_vld),  32'(m_own >= 0));
    chk("gnt_oh",   32'(gnt_oh),   (m_own >= 0) ? (32'd1 << m_gnt) : 32'd0);
    chk("busy",     32'(busy),     32'(m_acc));
    chk("tout_err", 32'(tout_err), 32'(m_terr));
    chk("tout_id",  32'(tout_id),  32'(m_tid));
  endtask

  task automatic cycle();
    @(posedge clk);
    if (!rst_n) model_reset(); else model_step();
    #1;
    cmp_model();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_gnt"},  32'(gnt), 0);
    chk({tag, "_vld"},  32'(gnt_vld), 0);
    chk({tag, "_oh"},   32'(gnt_oh), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_terr"}, 32'(tout_err), 0);
    chk({tag, "_tid"},  32'(tout_id), 0);
  endtask

  initial begin
    model_reset();
    rst_n = 1'b0; req = '0; req_ack = 1'b0; lack = 1'b0;
    // Reset and idle
    repeat (5) cycle();
    chk_zero("reset");
    rst_n = 1'b1;
    repeat (4) cycle();
    req = 4'b0100;
    cycle();
    chk("first_gnt", 32'(gnt), 2);
    chk("first_vld", 32'(gnt_vld), 1);
    chk("first_oh",  32'(gnt_oh), 32'b0100);
    req_ack = 1'b1; cycle(); req_ack = 1'b0; req = '0;
    chk("first_busy", 32'(busy), 1);
    lack = 1'b1; cycle(); lack = 1'b0;
    chk("first_done_vld", 32'(gnt_vld), 0);

    // Single burst from requester 0
    req = 4'b0001; cycle();
    chk("single_gnt", 32'(gnt), 0);
    req_ack = 1'b1; cycle(); req_ack = 1'b0; req = '0;
    chk("single_busy", 32'(busy), 1);
    repeat (3) begin cycle(); chk("single_busy_hold", 32'(busy), 1); end
    lack = 1'b1; cycle(); lack = 1'b0;
    chk("single_end_vld", 32'(gnt_vld), 0);
    chk("single_end_busy", 32'(busy), 0);

    // Round-robin fairness with all requesting
    req = 4'b1111; cycle();
    chk("rr_first", 32'(gnt), 1);
    for (int i = 0; i < 5; i++) begin
      req_ack = 1'b1; cycle(); req_ack = 1'b0;
      cycle();
      lack = 1'b1; cycle(); lack = 1'b0;
      chk("rr_order", 32'(gnt), 32'((2 + i) % 4));
      chk("rr_vld", 32'(gnt_vld), 1);
      chk("rr_busy", 32'(busy), 0);
    end
    req_ack = 1'b1; cycle(); req_ack = 1'b0; req = '0;
    lack = 1'b1; cycle(); lack = 1'b0;
    chk("rr_end_vld", 32'(gnt_vld), 0);

    // Same-cycle ack and last-data; sole requester is re-granted, busy never rises
    req = 4'b0010; cycle();
    chk("acklack_gnt", 32'(gnt), 1);
    req_ack = 1'b1; lack = 1'b1; cycle(); req_ack = 1'b0; lack = 1'b0;
    chk("acklack_busy", 32'(busy), 0);
    chk("acklack_regnt", 32'(gnt), 1);
    req = '0; cycle();
    chk("withdraw1_vld", 32'(gnt_vld), 0);

    // Withdrawal leaves rr_ptr at 1, so 0110 grants 2
    req = 4'b0100; cycle();
    chk("wd_gnt", 32'(gnt), 2);
    req = '0; cycle();
    chk("wd_vld", 32'(gnt_vld), 0);
    req = 4'b0110; cycle();
    chk("wd_ptr_gnt", 32'(gnt), 2);
    req_ack = 1'b1; cycle(); req_ack = 1'b0; req = '0;
    lack = 1'b1; cycle(); lack = 1'b0;

    // Watchdog expiry
    req = 4'b1000; cycle();
    chk("wdog_gnt", 32'(gnt), 3);
    req_ack = 1'b1; cycle(); req_ack = 1'b0; req = 4'b0001;
    chk("wdog_busy", 32'(busy), 1);
    for (int k = 1; k < TOUT; k++) begin
      cycle();
      chk("wdog_quiet", 32'(tout_err), 0);
    end
    cycle();
    chk("wdog_err", 32'(tout_err), 1);
    chk("wdog_id",  32'(tout_id), 3);
    chk("wdog_next", 32'(gnt), 0);
    chk("wdog_next_busy", 32'(busy), 0);
    cycle();
    chk("wdog_pulse", 32'(tout_err), 0);

    // Lack on the expiry cycle wins
    req_ack = 1'b1; cycle(); req_ack = 1'b0;
    for (int k = 1; k < TOUT; k++) cycle();
    lack = 1'b1; cycle(); lack = 1'b0;
    chk("wdog_lack_err", 32'(tout_err), 0);
    chk("wdog_lack_busy", 32'(busy), 0);

    // Asynchronous reset mid-burst
    req_ack = 1'b1; cycle(); req_ack = 1'b0;
    chk("mid_busy", 32'(busy), 1);
    #2 rst_n = 1'b0;
    #1 chk_zero("async_rst");
    model_reset();
    cycle();
    rst_n = 1'b1; req = '0;
    cycle();

    // Random traffic against the model
    for (int n = 0; n < 600; n++) begin
      req     = 4'($urandom_range(0, 15));
      req_ack = ($urandom % 3) == 0;
      lack    = ($urandom % 8) == 0;
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
